// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions.
// Holds the word/round counts, the key-schedule FSM state type, the word type
// and the GF(2^8) helpers (xtime, multiply, S-box) used by the controller and
// by the word-stage expander.
package aes_pkg;

  localparam int AES128_WORDS  = 44;
  localparam int AES128_ROUNDS = 11;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } ks_state_t;

  // Multiply by x in GF(2^8) with the AES polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    logic [7:0] shifted;
    shifted = {x[6:0], 1'b0};
    if (x[7]) begin
      return shifted ^ 8'h1b;
    end else begin
      return shifted;
    end
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] term;
    acc  = 8'h00;
    term = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc ^ term;
      end
      term = xtime(term);
    end
    return acc;
  endfunction

  // AES S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the affine transform. x^254 = x^2 * x^4 * ... * x^128.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Cipher-key handshake and round-key read port of the key-schedule controller.
//   key_valid/key_ready/key_in : 128-bit cipher key offer (valid/ready)
//   keys_valid                 : full expanded schedule available
//   rd_round/rd_key            : combinational round-key read
// master = key-register side, slave = key_schedule_ctrl.
interface key_schedule_ctrl_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
    output key_valid, key_in, rd_round,
    input  key_ready, keys_valid, rd_key
  );

  modport slave (
    input  key_valid, key_in, rd_round,
    output key_ready, keys_valid, rd_key
  );
endinterface

// File: rtl/key_expander.sv
// AES-128 key-expansion word stage; one registered word per request.
//   i        : word index being produced
//   key_i_1  : w[i-1]
//   key_N_i  : w[i-4]
//   rc_i     : round constant for i%4==0
//   key_out  : registered result, valid the cycle after the request.
// For i%4==0 the full word w[i-4]^SubWord(RotWord(w[i-1]))^{rc,0} is returned;
// otherwise w[i-1] is passed through and the caller applies the w[i-4] XOR.
module key_expander
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i,
  input  word_t       key_i_1,
  input  word_t       key_N_i,
  input  logic [7:0]  rc_i,
  output word_t       key_out
);

  word_t rot_s;
  word_t sub_s;
  word_t word_s;

  // Compute the word for the current request.
  always_comb begin
    rot_s  = {key_i_1[23:0], key_i_1[31:24]};
    sub_s  = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
    if ((i & 8'd3) == 8'd0) begin
      word_s = key_N_i ^ sub_s ^ {rc_i, 24'h000000};
    end else begin
      word_s = key_i_1;
    end
  end

  // Register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out <= 32'h0000_0000;
    end else begin
      key_out <= word_s;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer.
// Accepts a cipher key over key_if (valid/ready), requests words 4..43 from an
// external key_expander via the registered exp_* outputs, completes each word
// on the returned exp_key_out and stores the 44-word schedule. Round keys are
// read combinationally through key_if.rd_round/rd_key once keys_valid is set.
// Ports: clk, rst_n (async active-low), key_if (slave), exp_i, exp_key_i_1,
// exp_key_N_i, exp_rc_i (to expander), exp_key_out (from expander).
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_SIZE   = AES128_WORDS / AES128_ROUNDS,
  parameter int NUM_ROUNDS = KEY_SIZE + 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_schedule_ctrl_if.slave   key_if,
  output logic [7:0]           exp_i,
  output word_t                exp_key_i_1,
  output word_t                exp_key_N_i,
  output logic [7:0]           exp_rc_i,
  input  word_t                exp_key_out
);

  localparam int NUM_WORDS  = KEY_SIZE * NUM_ROUNDS;
  localparam int LAST_INDEX = NUM_WORDS - 1;

  ks_state_t   state_r;
  ks_state_t   state_next_s;
  logic        key_ready_s;
  logic        accept_s;
  logic        keys_valid_r;
  logic [5:0]  index_r;
  logic [7:0]  rcon_r;
  word_t       words_r [NUM_WORDS];
  word_t       new_word_s;
  logic [7:0]  rcon_after_s;
  logic [5:0]  index_inc_s;
  logic [5:0]  rd_base_s;
  logic [7:0]  exp_i_r;
  word_t       exp_key_i_1_r;
  word_t       exp_key_N_i_r;
  logic [7:0]  exp_rc_i_r;
  logic [127:0] rd_key_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, handshake decode.
  always_comb begin
    state_next_s = state_r;
    key_ready_s  = (state_r == IDLE) || (state_r == DONE);
    accept_s     = key_if.key_valid && key_ready_s;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = state_r;
        end
      end
      ISSUE: state_next_s = CAPTURE;
      CAPTURE: begin
        if (index_r == 6'(LAST_INDEX)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Finish the captured word; the expander only produces the full word for
  // multiples of four, other words need the w[i-4] XOR applied here.
  always_comb begin
    index_inc_s = index_r + 6'd1;
    if (index_r[1:0] == 2'b00) begin
      new_word_s   = exp_key_out;
      rcon_after_s = xtime(rcon_r);
    end else begin
      new_word_s   = exp_key_out ^ words_r[index_r - 6'd4];
      rcon_after_s = rcon_r;
    end
  end

  // keys_valid follows the state so it rises on the edge that enters DONE
  // and falls on the edge that accepts a new key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_valid_r <= 1'b0;
    end else begin
      keys_valid_r <= (state_next_s == DONE);
    end
  end

  // Word store, index/rcon and registered expander request.
  // The request for word i+1 is launched on the edge that completes word i,
  // so the freshly completed word feeds exp_key_i_1 directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        words_r[k] <= 32'h0000_0000;
      end
      index_r       <= 6'd0;
      rcon_r        <= 8'h01;
      exp_i_r       <= 8'h00;
      exp_key_i_1_r <= 32'h0000_0000;
      exp_key_N_i_r <= 32'h0000_0000;
      exp_rc_i_r    <= 8'h00;
    end else if (accept_s) begin
      words_r[0]    <= key_if.key_in[127:96];
      words_r[1]    <= key_if.key_in[95:64];
      words_r[2]    <= key_if.key_in[63:32];
      words_r[3]    <= key_if.key_in[31:0];
      index_r       <= 6'd4;
      rcon_r        <= 8'h01;
      exp_i_r       <= 8'd4;
      exp_key_i_1_r <= key_if.key_in[31:0];
      exp_key_N_i_r <= key_if.key_in[127:96];
      exp_rc_i_r    <= 8'h01;
    end else if (state_r == CAPTURE) begin
      words_r[index_r] <= new_word_s;
      rcon_r           <= rcon_after_s;
      if (index_r != 6'(LAST_INDEX)) begin
        index_r       <= index_inc_s;
        exp_i_r       <= {2'b00, index_inc_s};
        exp_key_i_1_r <= new_word_s;
        exp_key_N_i_r <= words_r[index_r - 6'd3];
        exp_rc_i_r    <= rcon_after_s;
      end
    end
  end

  // Round-key read; zero while the schedule is invalid or the round is out of range.
  always_comb begin
    rd_base_s = {key_if.rd_round, 2'b00};
    if (keys_valid_r && (key_if.rd_round < 4'(NUM_ROUNDS))) begin
      rd_key_s = {words_r[rd_base_s], words_r[rd_base_s + 6'd1],
                  words_r[rd_base_s + 6'd2], words_r[rd_base_s + 6'd3]};
    end else begin
      rd_key_s = 128'h0;
    end
  end

  assign key_if.key_ready  = key_ready_s;
  assign key_if.keys_valid = keys_valid_r;
  assign key_if.rd_key     = rd_key_s;
  assign exp_i             = exp_i_r;
  assign exp_key_i_1       = exp_key_i_1_r;
  assign exp_key_N_i       = exp_key_N_i_r;
  assign exp_rc_i          = exp_rc_i_r;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed self-checking bench for key_schedule_ctrl driving a key_expander.
module tb_key_schedule_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic       clk;
  logic       rst_n;
  logic [7:0] exp_i;
  word_t      exp_key_i_1;
  word_t      exp_key_N_i;
  logic [7:0] exp_rc_i;
  word_t      exp_key_out;
  int         checks;
  int         errors;

  key_schedule_ctrl_if ks_if ();

  key_schedule_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_if     (ks_if),
    .exp_i      (exp_i),
    .exp_key_i_1(exp_key_i_1),
    .exp_key_N_i(exp_key_N_i),
    .exp_rc_i   (exp_rc_i),
    .exp_key_out(exp_key_out)
  );

  key_expander u_exp (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (exp_i),
    .key_i_1(exp_key_i_1),
    .key_N_i(exp_key_N_i),
    .rc_i   (exp_rc_i),
    .key_out(exp_key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer a key at a negedge, release it after the accepting edge and count
  // rising edges until keys_valid is seen (200 means the bound expired).
  task automatic run_key(input logic [127:0] key, output int edges);
    @(negedge clk);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = key;
    @(posedge clk);
    @(negedge clk);
    ks_if.key_valid = 1'b0;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (ks_if.keys_valid) break;
    end
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    ks_if.key_valid = 1'b0;
    ks_if.key_in   = 128'h0;
    ks_if.rd_round = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (ks_if.key_ready !== 1'b1) begin
      errors++; $display("FAIL reset_key_ready got %b exp 1", ks_if.key_ready);
    end
    checks++;
    if (ks_if.keys_valid !== 1'b0) begin
      errors++; $display("FAIL reset_keys_valid got %b exp 0", ks_if.keys_valid);
    end
    checks++;
    if ({exp_i, exp_key_i_1, exp_key_N_i, exp_rc_i} !== 80'h0) begin
      errors++; $display("FAIL reset_exp got %h exp 0", {exp_i, exp_key_i_1, exp_key_N_i, exp_rc_i});
    end
    checks++;
    if (ks_if.rd_key !== 128'h0) begin
      errors++; $display("FAIL reset_rd_key got %h exp 0", ks_if.rd_key);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips;
    int edges;
    run_key(FIPS_KEY, edges);
    checks++;
    if (edges !== 80) begin
      errors++; $display("FAIL fips_latency got %0d exp 80", edges);
    end
    @(negedge clk);
    ks_if.rd_round = 4'd1;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_R1) begin
      errors++; $display("FAIL fips_round1 got %h exp %h", ks_if.rd_key, FIPS_R1);
    end
    ks_if.rd_round = 4'd10;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_R10) begin
      errors++; $display("FAIL fips_round10 got %h exp %h", ks_if.rd_key, FIPS_R10);
    end
    checks++;
    if (ks_if.key_ready !== 1'b1) begin
      errors++; $display("FAIL fips_done_ready got %b exp 1", ks_if.key_ready);
    end
  endtask

  task automatic test_zero_key;
    int         edges;
    int         n;
    logic [7:0] prev_i;
    logic [7:0] rc_seen [10];
    logic [7:0] rc_exp  [10];
    rc_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    n = 0;
    @(negedge clk);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = 128'h0;
    @(posedge clk);
    #1;
    ks_if.key_valid = 1'b0;
    prev_i = exp_i;
    if (exp_i[1:0] == 2'b00) begin
      rc_seen[n] = exp_rc_i;
      n++;
    end
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (exp_i != prev_i) begin
        prev_i = exp_i;
        if (exp_i[1:0] == 2'b00 && n < 10) begin
          rc_seen[n] = exp_rc_i;
          n++;
        end
      end
      if (ks_if.keys_valid) break;
    end
    checks++;
    if (edges !== 80) begin
      errors++; $display("FAIL zero_latency got %0d exp 80", edges);
    end
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL zero_rc_count got %0d exp 10", n);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rc_seen[k] !== rc_exp[k]) begin
        errors++; $display("FAIL zero_rc_i%0d got %h exp %h", 4 * (k + 1), rc_seen[k], rc_exp[k]);
      end
    end
    ks_if.rd_round = 4'd1;
    #1;
    checks++;
    if (ks_if.rd_key !== ZERO_R1) begin
      errors++; $display("FAIL zero_round1 got %h exp %h", ks_if.rd_key, ZERO_R1);
    end
    ks_if.rd_round = 4'd10;
    #1;
    checks++;
    if (ks_if.rd_key !== ZERO_R10) begin
      errors++; $display("FAIL zero_round10 got %h exp %h", ks_if.rd_key, ZERO_R10);
    end
  endtask

  task automatic test_busy;
    int edges;
    @(negedge clk);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = FIPS_KEY;
    @(posedge clk);
    @(negedge clk);
    ks_if.key_in = 128'h0;  // a different key keeps being offered while busy
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 40) begin
        checks++;
        if (ks_if.key_ready !== 1'b0) begin
          errors++; $display("FAIL busy_key_ready got %b exp 0", ks_if.key_ready);
        end
      end
      if (ks_if.keys_valid) begin
        ks_if.key_valid = 1'b0;
        break;
      end
    end
    checks++;
    if (edges !== 80) begin
      errors++; $display("FAIL busy_latency got %0d exp 80", edges);
    end
    ks_if.rd_round = 4'd10;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_R10) begin
      errors++; $display("FAIL busy_round10 got %h exp %h", ks_if.rd_key, FIPS_R10);
    end
    ks_if.rd_round = 4'd1;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_R1) begin
      errors++; $display("FAIL busy_round1 got %h exp %h", ks_if.rd_key, FIPS_R1);
    end
  endtask

  task automatic test_reset_mid;
    int edges;
    int cyc;
    @(negedge clk);
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = FIPS_KEY;
    @(posedge clk);
    @(negedge clk);
    ks_if.key_valid = 1'b0;
    cyc = 0;
    while (cyc < 200 && exp_i != 8'd20) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    checks++;
    if (exp_i !== 8'd20) begin
      errors++; $display("FAIL mid_reach_20 got %0d exp 20", exp_i);
    end
    rst_n = 1'b0;
    ks_if.rd_round = 4'd1;
    #2;
    checks++;
    if (ks_if.keys_valid !== 1'b0) begin
      errors++; $display("FAIL mid_keys_valid got %b exp 0", ks_if.keys_valid);
    end
    checks++;
    if (ks_if.key_ready !== 1'b1) begin
      errors++; $display("FAIL mid_key_ready got %b exp 1", ks_if.key_ready);
    end
    checks++;
    if (ks_if.rd_key !== 128'h0) begin
      errors++; $display("FAIL mid_rd_key got %h exp 0", ks_if.rd_key);
    end
    checks++;
    if (exp_i !== 8'd0) begin
      errors++; $display("FAIL mid_exp_i got %0d exp 0", exp_i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_key(128'h0, edges);
    checks++;
    if (edges !== 80) begin
      errors++; $display("FAIL mid_fresh_latency got %0d exp 80", edges);
    end
    ks_if.rd_round = 4'd10;
    #1;
    checks++;
    if (ks_if.rd_key !== ZERO_R10) begin
      errors++; $display("FAIL mid_fresh_round10 got %h exp %h", ks_if.rd_key, ZERO_R10);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    @(negedge clk);
    checks++;
    if (ks_if.keys_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_pre_valid got %b exp 1", ks_if.keys_valid);
    end
    ks_if.key_valid = 1'b1;
    ks_if.key_in    = FIPS_KEY;
    @(posedge clk);
    #1;
    ks_if.key_valid = 1'b0;
    checks++;
    if (ks_if.keys_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_valid_drop got %b exp 0", ks_if.keys_valid);
    end
    checks++;
    if (ks_if.key_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_key_ready got %b exp 0", ks_if.key_ready);
    end
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (ks_if.keys_valid) break;
    end
    checks++;
    if (edges !== 80) begin
      errors++; $display("FAIL b2b_latency got %0d exp 80", edges);
    end
    ks_if.rd_round = 4'd10;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_R10) begin
      errors++; $display("FAIL b2b_round10 got %h exp %h", ks_if.rd_key, FIPS_R10);
    end
  endtask

  task automatic test_rd_range;
    logic [3:0] r;
    ks_if.rd_round = 4'd0;
    #1;
    checks++;
    if (ks_if.rd_key !== FIPS_KEY) begin
      errors++; $display("FAIL rd_round0 got %h exp %h", ks_if.rd_key, FIPS_KEY);
    end
    for (int k = 11; k < 16; k++) begin
      r = 4'(k);
      ks_if.rd_round = r;
      #1;
      checks++;
      if (ks_if.rd_key !== 128'h0) begin
        errors++; $display("FAIL rd_round%0d got %h exp 0", k, ks_if.rd_key);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fips();
    test_zero_key();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_rd_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
